// File: rtl/fft_pkg.sv
// fft_pkg: default widths and Q-format constants shared by the forward and inverse butterfly blocks.
package fft_pkg;
  localparam int FFT_DATA_WIDTH   = 32;
  localparam int FFT_FACTOR_WIDTH = 16;
  localparam int FFT_FRAC_BITS    = 14;
  localparam int ONE_Q            = 1 << FFT_FRAC_BITS;
endpackage

// File: rtl/cmul_conj_pipe.sv
// cmul_conj_pipe: two-stage D*conj(W) multiply, products then scaled sums.
// IBF_ROUND_EN selects round-half-up on the final slice instead of floor.
module cmul_conj_pipe import fft_pkg::*; #(
  parameter int DATA_WIDTH   = FFT_DATA_WIDTH,
  parameter int FACTOR_WIDTH = FFT_FACTOR_WIDTH,
  parameter int FRAC_BITS    = FFT_FRAC_BITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic signed [DATA_WIDTH-1:0]   dr,
  input  logic signed [DATA_WIDTH-1:0]   di,
  input  logic signed [FACTOR_WIDTH-1:0] wr,
  input  logic signed [FACTOR_WIDTH-1:0] wi,
  output logic signed [DATA_WIDTH-1:0]   re,
  output logic signed [DATA_WIDTH-1:0]   im
);
  localparam int PW = DATA_WIDTH + FACTOR_WIDTH;
`ifdef IBF_ROUND_EN
  localparam logic signed [PW:0] RND = PW'(1) << (FRAC_BITS - 1);
`else
  localparam logic signed [PW:0] RND = '0;
`endif
  logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri;
  logic signed [PW:0] s_re, s_im;
  always_comb begin
    s_re = (PW+1)'(p_rr) + (PW+1)'(p_ii) + RND;
    s_im = (PW+1)'(p_ir) - (PW+1)'(p_ri) + RND;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p_rr <= '0;
      p_ii <= '0;
      p_ir <= '0;
      p_ri <= '0;
      re   <= '0;
      im   <= '0;
    end else if (en) begin
      p_rr <= dr * wr;
      p_ii <= di * wi;
      p_ir <= di * wr;
      p_ri <= dr * wi;
      re   <= DATA_WIDTH'(s_re >>> FRAC_BITS);
      im   <= DATA_WIDTH'(s_im >>> FRAC_BITS);
    end
endmodule

// File: rtl/ibf_pipe.sv
// ibf_pipe: 3-stage inverse radix-2 butterfly, X0=(A+B)/2, X1=((A-B)/2)*conj(W).
// IBF_ROUND_EN (optional) rounds the final twiddle slice; halving always floors.
module ibf_pipe import fft_pkg::*; #(
  parameter int DATA_WIDTH   = FFT_DATA_WIDTH,
  parameter int FACTOR_WIDTH = FFT_FACTOR_WIDTH,
  parameter int FRAC_BITS    = FFT_FRAC_BITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*DATA_WIDTH-1:0]   in_a,
  input  logic [2*DATA_WIDTH-1:0]   in_b,
  input  logic [2*FACTOR_WIDTH-1:0] w,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   out_x0,
  output logic [2*DATA_WIDTH-1:0]   out_x1
);
  localparam int DW = DATA_WIDTH;
  localparam int FW = FACTOR_WIDTH;
  logic en, v1, v2, v3;
  logic signed [DW:0] s_sr, s_si, s_dr, s_di;
  logic signed [DW-1:0] h_sr, h_si, h_dr, h_di, x1r, x1i;
  logic signed [FW-1:0] wr, wi;
  logic [2*DW-1:0] x0_s2;
  assign en        = !v3 || out_ready;
  assign in_ready  = en;
  assign out_valid = v3;
  assign out_x1    = {x1r, x1i};
  always_comb begin
    s_sr = (DW+1)'($signed(in_a[2*DW-1:DW])) + (DW+1)'($signed(in_b[2*DW-1:DW]));
    s_si = (DW+1)'($signed(in_a[DW-1:0]))    + (DW+1)'($signed(in_b[DW-1:0]));
    s_dr = (DW+1)'($signed(in_a[2*DW-1:DW])) - (DW+1)'($signed(in_b[2*DW-1:DW]));
    s_di = (DW+1)'($signed(in_a[DW-1:0]))    - (DW+1)'($signed(in_b[DW-1:0]));
  end
  // every stage moves together on en, so bubbles keep their slot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {v1, v2, v3}           <= '0;
      {h_sr, h_si, h_dr, h_di} <= '0;
      {wr, wi}               <= '0;
      x0_s2                  <= '0;
      out_x0                 <= '0;
    end else if (en) begin
      v1     <= in_valid;
      v2     <= v1;
      v3     <= v2;
      h_sr   <= DW'(s_sr >>> 1);
      h_si   <= DW'(s_si >>> 1);
      h_dr   <= DW'(s_dr >>> 1);
      h_di   <= DW'(s_di >>> 1);
      wr     <= $signed(w[2*FW-1:FW]);
      wi     <= $signed(w[FW-1:0]);
      x0_s2  <= {h_sr, h_si};
      out_x0 <= x0_s2;
    end
  cmul_conj_pipe #(
    .DATA_WIDTH  (DW),
    .FACTOR_WIDTH(FW),
    .FRAC_BITS   (FRAC_BITS)
  ) u_cmul (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .dr   (h_dr),
    .di   (h_di),
    .wr   (wr),
    .wi   (wi),
    .re   (x1r),
    .im   (x1i)
  );
endmodule

// File: tb/tb_ibf_pipe.sv
// tb_ibf_pipe: directed checks of ibf_pipe at default widths, including stall, reset and round-trip cases.
module tb_ibf_pipe;
  import fft_pkg::*;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_a, in_b, out_x0, out_x1;
  logic [31:0] w;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  ibf_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .w        (w),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x0   (out_x0),
    .out_x1   (out_x1)
  );
  function automatic logic [63:0] cx(int r, int i);
    return {r[31:0], i[31:0]};
  endfunction
  function automatic logic [31:0] cw(int r, int i);
    return {r[15:0], i[15:0]};
  endfunction
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic near(string tag, int got, int want);
    vecs++;
    assert (got - want <= 2 && want - got <= 2) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d +-2", tag, got, want);
    end
  endtask
  task automatic run1(string tag, logic [63:0] a, logic [63:0] b, logic [31:0] tw,
                      logic [63:0] ex0, logic [63:0] ex1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a = a;
    in_b = b;
    w    = tw;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_lat2"}, out_valid, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_x0"}, out_x0, ex0);
    chk({tag, "_x1"}, out_x1, ex1);
    @(posedge clk); #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [63:0] sa[8], sb[8], e0[8], e1[8], h0, h1;
    int sent, rcv, r3a, r3b, x0r, x0i, x1r, x1i, tr, ti;
    int wtab[8][2];
    logic stale;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; w = '0;
    #3;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_x0", out_x0, 64'd0);
    chk("rst_x1", out_x1, 64'd0);
    chk("rst_ready", in_ready, 1'b1);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run1("case1", cx(300, 100), cx(100, -50), cw(ONE_Q, 0), cx(200, 25), cx(100, 75));
    run1("case2", cx(300, 100), cx(100, -50), cw(0, -ONE_Q), cx(200, 25), cx(-75, 100));
`ifdef IBF_ROUND_EN
    r3a = 1; r3b = 0;
`else
    r3a = 0; r3b = -1;
`endif
    run1("case3p", cx(16384, 0), cx(0, 0), cw(1, 0), cx(8192, 0), cx(r3a, 0));
    run1("case3n", cx(-16384, 0), cx(0, 0), cw(1, 0), cx(-8192, 0), cx(r3b, 0));
    // stream of 8 beats with out_ready low in cycles 4-6
    for (int i = 0; i < 8; i++) begin
      sa[i] = cx(100 * i + 7, -30 * i);
      sb[i] = cx(20 * i + 1, 5 * i + 3);
      e0[i] = cx((100 * i + 7 + 20 * i + 1) >>> 1, (-30 * i + 5 * i + 3) >>> 1);
      e1[i] = cx((100 * i + 7 - 20 * i - 1) >>> 1, (-30 * i - 5 * i - 3) >>> 1);
    end
    w = cw(ONE_Q, 0);
    sent = 0; rcv = 0; h0 = '0; h1 = '0;
    for (int c = 0; c < 40 && rcv < 8; c++) begin
      out_ready = !(c >= 4 && c <= 6);
      in_valid  = sent < 8;
      if (sent < 8) begin
        in_a = sa[sent];
        in_b = sb[sent];
      end
      #3;
      if (c >= 4 && c <= 6) begin
        chk("stall_ready", in_ready, 1'b0);
        if (c == 4) begin
          h0 = out_x0;
          h1 = out_x1;
        end else begin
          chk("stall_hold_x0", out_x0, h0);
          chk("stall_hold_x1", out_x1, h1);
          chk("stall_hold_v", out_valid, 1'b1);
        end
      end
      if (out_valid && out_ready) begin
        chk($sformatf("stream%0d_x0", rcv), out_x0, e0[rcv]);
        chk($sformatf("stream%0d_x1", rcv), out_x1, e1[rcv]);
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_sent", 64'(sent), 64'd8);
    chk("stream_rcv", 64'(rcv), 64'd8);
    @(posedge clk); #1;
    chk("stream_drained", out_valid, 1'b0);
    // reset with two beats in flight and the first one stalled at the output
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = cx(50, 50); in_b = cx(10, 10);
    @(posedge clk); #1;
    in_a = cx(60, 60);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_x0", out_x0, 64'd0);
    chk("mid_rst_x1", out_x1, 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_ready", in_ready, 1'b1);
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      stale |= out_valid;
    end
    chk("post_rst_stale", stale, 1'b0);
    // forward butterfly feeding the inverse; unit-magnitude twiddles
    wtab = '{'{16384, 0}, '{0, 16384}, '{11585, 11585}, '{-11585, 11585},
             '{15137, -6270}, '{-16384, 0}, '{6270, -15137}, '{-11585, -11585}};
    for (int t = 0; t < 8; t++) begin
      x0r = int'($urandom_range(200000)) - 100000;
      x0i = int'($urandom_range(200000)) - 100000;
      x1r = int'($urandom_range(8000)) - 4000;
      x1i = int'($urandom_range(8000)) - 4000;
      tr = (x1r * wtab[t][0] - x1i * wtab[t][1] + 8192) >>> 14;
      ti = (x1r * wtab[t][1] + x1i * wtab[t][0] + 8192) >>> 14;
      in_valid = 1'b1;
      in_a = cx(x0r + tr, x0i + ti);
      in_b = cx(x0r - tr, x0i - ti);
      w = cw(wtab[t][0], wtab[t][1]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk($sformatf("rt%0d_valid", t), out_valid, 1'b1);
      near($sformatf("rt%0d_x0r", t), int'($signed(out_x0[63:32])), x0r);
      near($sformatf("rt%0d_x0i", t), int'($signed(out_x0[31:0])), x0i);
      near($sformatf("rt%0d_x1r", t), int'($signed(out_x1[63:32])), x1r);
      near($sformatf("rt%0d_x1i", t), int'($signed(out_x1[31:0])), x1i);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
